// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and transmit sequencer feeding the UART transmitter
//
// Buffers bytes pushed from the clk domain and hands them one at a time to the
// UART transmitter over newd/dintx/donetx, watching the serial tx line so each
// popped byte starts exactly one frame.
//
// Ports:
//   clk, rst        system clock; synchronous active-high reset
//   wr_en, wr_data  push request and byte
//   full, empty     count == DEPTH / count == 0
//   count           bytes stored, excluding the byte handed to the transmitter
//   overflow        sticky flag, set when a push is dropped
//   busy            sequencer not idle
//   newd, dintx     start request and byte to the transmitter
//   tx              transmitter serial output (monitored)
//   donetx          transmitter completion flag (one uclk period wide)

module uart_tx_fifo #(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic          busy,
   output logic          newd,
   output logic [7:0]    dintx,
   input  logic          tx,
   input  logic          donetx
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE, GAP} state_t;

   state_t        state;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic          tx_q;
   logic          done_q;
   logic          tx_fall;
   logic          done_rise;
   logic          pop;
   logic          push;
   logic [AW:0]   count_nxt;

   assign tx_fall   = tx_q & ~tx;
   assign done_rise = donetx & ~done_q;

   // The sequencer pops whenever it is idle and has data. A push into a full
   // FIFO is still accepted in that cycle because the pop frees a slot.
   assign pop  = (state == IDLE) && (count != '0);
   assign push = wr_en && ((count != DEPTH_C) || pop);

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + (AW+1)'(1);
         2'b01:   count_nxt = count - (AW+1)'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wp] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp       <= '0;
         rp       <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
         tx_q     <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         tx_q   <= tx;
         done_q <= donetx;
         count  <= count_nxt;
         full   <= (count_nxt == DEPTH_C);
         empty  <= (count_nxt == '0);
         if (push) begin
            wp <= wp + AW'(1);
         end
         if (pop) begin
            rp <= rp + AW'(1);
         end
         if (wr_en && !push) begin
            overflow <= 1'b1;
         end
      end
   end

   // newd is held until the transmitter's start bit appears on tx; the
   // transmitter only samples newd on uclk edges while idle, so dropping it on
   // the start bit means exactly one frame per popped byte. GAP keeps newd from
   // re-asserting in the same cycle as the completion edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         newd  <= 1'b0;
         busy  <= 1'b0;
         dintx <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  dintx <= mem[rp];
                  newd  <= 1'b1;
                  busy  <= 1'b1;
                  state <= REQ;
               end
            end
            REQ: begin
               if (tx_fall) begin
                  newd  <= 1'b0;
                  state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (done_rise) begin
                  state <= GAP;
               end
            end
            GAP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               newd  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with transmitter model

module tb_uart_tx_fifo;

   localparam int DEPTH = 16;
   localparam int DIV   = 16;   // clk cycles per uclk period of the transmitter model

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic       busy;
   logic       newd;
   logic [7:0] dintx;
   logic       tx;
   logic       donetx;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .busy     (busy),
      .newd     (newd),
      .dintx    (dintx),
      .tx       (tx),
      .donetx   (donetx)
   );

   // Transmitter model: samples newd on uclk ticks while idle, sends 8N1
   // LSB-first, then raises donetx for one uclk period.
   int         div_cnt;
   int         ts;
   int         tn;
   logic [7:0] tsh;

   always @(posedge clk) begin
      if (rst) begin
         div_cnt <= 0;
         ts      <= 0;
         tn      <= 0;
         tsh     <= 8'h00;
         tx      <= 1'b1;
         donetx  <= 1'b0;
      end else begin
         div_cnt <= (div_cnt == DIV-1) ? 0 : div_cnt + 1;
         if (div_cnt == DIV-1) begin
            case (ts)
               0: begin
                  donetx <= 1'b0;
                  if (newd) begin
                     tsh <= dintx;
                     tx  <= 1'b0;
                     tn  <= 0;
                     ts  <= 1;
                  end
               end
               1: begin
                  tx <= tsh[tn];
                  if (tn == 7) ts <= 2;
                  else tn <= tn + 1;
               end
               2: begin
                  tx <= 1'b1;
                  ts <= 3;
               end
               default: begin
                  donetx <= 1'b1;
                  ts     <= 0;
               end
            endcase
         end
      end
   end

   // Serial decoder: finds the start bit and samples each data bit mid-period.
   int         dst;
   int         dcnt;
   int         dbit;
   logic [7:0] dbyte;
   logic       tx_prev;
   logic [7:0] rx_q [$];

   always @(posedge clk) begin
      if (rst) begin
         dst     <= 0;
         dcnt    <= 0;
         dbit    <= 0;
         dbyte   <= 8'h00;
         tx_prev <= 1'b1;
      end else begin
         tx_prev <= tx;
         case (dst)
            0: if (tx_prev && !tx) begin
                  dcnt <= DIV + DIV/2 - 1;
                  dbit <= 0;
                  dst  <= 1;
               end
            1: if (dcnt == 0) begin
                  dbyte <= {tx, dbyte[7:1]};
                  dcnt  <= DIV - 1;
                  if (dbit == 7) begin
                     rx_q.push_back({tx, dbyte[7:1]});
                     dst <= 2;
                  end else begin
                     dbit <= dbit + 1;
                  end
               end else begin
                  dcnt <= dcnt - 1;
               end
            default: if (dcnt == 0) dst <= 0;
                     else dcnt <= dcnt - 1;
         endcase
      end
   end

   // Reference model: a byte queue, a one-deep "in flight" slot that frees two
   // cycles after the transmitter's completion rises, and the push/drop rule.
   logic [7:0] m_q   [$];
   logic [7:0] exp_q [$];
   bit         m_free;
   bit         m_ovf;
   bit         m_done_prev;
   int         m_gap;

   task automatic step();
      bit pop, acc, drise;
      if (rst) begin
         m_q.delete();
         m_free      = 1'b1;
         m_ovf       = 1'b0;
         m_gap       = 0;
         m_done_prev = 1'b0;
      end else begin
         drise       = donetx && !m_done_prev;
         m_done_prev = donetx;
         pop = m_free && (m_q.size() > 0);
         acc = wr_en && ((m_q.size() < DEPTH) || pop);
         if (pop) begin
            exp_q.push_back(m_q.pop_front());
            m_free = 1'b0;
         end
         if (acc) m_q.push_back(wr_data);
         else if (wr_en) m_ovf = 1'b1;
         if (m_gap > 0) begin
            m_gap = m_gap - 1;
            if (m_gap == 0) m_free = 1'b1;
         end else if (!m_free && drise) begin
            m_gap = 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (!(m_free && m_q.size() == 0 && ts == 0 && !donetx && dst == 0) && n < 20000) begin
         step();
         n++;
      end
      checks++;
      if (n >= 20000) begin
         errors++;
         $display("FAIL drain_timeout: waited %0d cycles, required < 20000", n);
      end
   endtask

   task automatic test_reset();
      int bad = 0;
      rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
      repeat (3) step();
      checks++; if (count !== 5'd0)    begin errors++; $display("FAIL reset_count: got %0d required 0", count); end
      checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL reset_empty: got %b required 1", empty); end
      checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b required 0", full); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
      checks++; if (newd !== 1'b0)     begin errors++; $display("FAIL reset_newd: got %b required 0", newd); end
      checks++; if (dintx !== 8'h00)   begin errors++; $display("FAIL reset_dintx: got %h required 00", dintx); end
      rst = 1'b0;
      repeat (2000) begin
         step();
         if (empty !== 1'b1 || count !== 5'd0 || newd !== 1'b0 || tx !== 1'b1) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL idle_quiet: %0d bad cycles, required 0", bad); end
   endtask

   task automatic test_single();
      int  n;
      bit  saw_done = 1'b0;
      rx_q.delete(); exp_q.delete();
      wr_en = 1'b1; wr_data = 8'hA5;
      step();
      wr_en = 1'b0;
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count1: got %0d required 1", count); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty: got %b required 0", empty); end
      checks++; if (newd !== 1'b0)  begin errors++; $display("FAIL single_newd_early: got %b required 0", newd); end
      step();
      checks++; if (newd !== 1'b1)    begin errors++; $display("FAIL single_newd: got %b required 1", newd); end
      checks++; if (dintx !== 8'hA5)  begin errors++; $display("FAIL single_dintx: got %h required a5", dintx); end
      checks++; if (count !== 5'd0)   begin errors++; $display("FAIL single_count0: got %0d required 0", count); end
      checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL single_busy: got %b required 1", busy); end
      n = 0;
      while (tx !== 1'b0 && n < 200) begin step(); n++; end
      checks++; if (n >= 200) begin errors++; $display("FAIL single_start_bit: waited %0d cycles, required < 200", n); end
      n = 0;
      while (newd !== 1'b0 && n < 200) begin step(); n++; end
      checks++; if (n > DIV + 2) begin errors++; $display("FAIL single_newd_fall: %0d cycles after start bit, required <= %0d", n, DIV + 2); end
      checks++; if (dintx !== 8'hA5) begin errors++; $display("FAIL single_dintx_hold: got %h required a5", dintx); end
      n = 0;
      while (busy !== 1'b0 && n < 400) begin
         if (donetx) saw_done = 1'b1;
         step(); n++;
      end
      checks++; if (!(n < 400 && saw_done)) begin errors++; $display("FAIL single_busy_end: cycles %0d done_seen %b, required < 400 and 1", n, saw_done); end
      drain();
      checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL single_frames: got %0d required 1", rx_q.size()); end
      else begin
         checks++; if (rx_q[0] !== 8'hA5) begin errors++; $display("FAIL single_frame_data: got %h required a5", rx_q[0]); end
      end
   endtask

   task automatic test_burst();
      int peak = 0;
      rx_q.delete(); exp_q.delete();
      for (int i = 1; i <= 5; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         step();
         if (int'(count) > peak) peak = int'(count);
      end
      wr_en = 1'b0;
      repeat (4) begin
         step();
         if (int'(count) > peak) peak = int'(count);
      end
      checks++; if (peak !== 4) begin errors++; $display("FAIL burst_peak: got %0d required 4", peak); end
      drain();
      checks++; if (rx_q.size() !== 5) begin errors++; $display("FAIL burst_frames: got %0d required 5", rx_q.size()); end
      for (int i = 0; i < rx_q.size() && i < 5; i++) begin
         checks++;
         if (rx_q[i] !== 8'(i + 1)) begin errors++; $display("FAIL burst_frame%0d: got %h required %h", i, rx_q[i], 8'(i + 1)); end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] sent [18];
      bit         full_ok = 1'b1;
      rx_q.delete(); exp_q.delete();
      for (int i = 0; i < 18; i++) begin
         sent[i] = 8'($urandom);
         wr_en = 1'b1; wr_data = sent[i];
         step();
         if (count == 5'd16 && full !== 1'b1) full_ok = 1'b0;
      end
      wr_en = 1'b0;
      checks++; if (count !== 5'd16)   begin errors++; $display("FAIL ovf_count: got %0d required 16", count); end
      checks++; if (!(full === 1'b1 && full_ok)) begin errors++; $display("FAIL ovf_full: got %b required 1", full); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b required 1", overflow); end
      drain();
      checks++; if (rx_q.size() !== 17) begin errors++; $display("FAIL ovf_frames: got %0d required 17", rx_q.size()); end
      for (int i = 0; i < rx_q.size() && i < 17; i++) begin
         checks++;
         if (rx_q[i] !== sent[i]) begin errors++; $display("FAIL ovf_frame%0d: got %h required %h", i, rx_q[i], sent[i]); end
      end
   endtask

   task automatic test_full_push();
      logic [7:0] sent [18];
      int         n = 0;
      rst = 1'b1; step(); rst = 1'b0;
      rx_q.delete(); exp_q.delete();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpush_ovf_clear: got %b required 0", overflow); end
      for (int i = 0; i < 17; i++) begin
         sent[i] = 8'($urandom);
         wr_en = 1'b1; wr_data = sent[i];
         step();
      end
      wr_en = 1'b0;
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL fullpush_fill: got %0d required 16", count); end
      while (busy !== 1'b0 && n < 400) begin step(); n++; end
      checks++; if (n >= 400) begin errors++; $display("FAIL fullpush_idle_wait: waited %0d cycles, required < 400", n); end
      sent[17] = 8'($urandom);
      wr_en = 1'b1; wr_data = sent[17];
      step();
      wr_en = 1'b0;
      checks++; if (count !== 5'd16)   begin errors++; $display("FAIL fullpush_count: got %0d required 16", count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpush_ovf: got %b required 0", overflow); end
      checks++; if (full !== 1'b1)     begin errors++; $display("FAIL fullpush_full: got %b required 1", full); end
      drain();
      checks++; if (rx_q.size() !== 18) begin errors++; $display("FAIL fullpush_frames: got %0d required 18", rx_q.size()); end
      for (int i = 0; i < rx_q.size() && i < 18; i++) begin
         checks++;
         if (rx_q[i] !== sent[i]) begin errors++; $display("FAIL fullpush_frame%0d: got %h required %h", i, rx_q[i], sent[i]); end
      end
   endtask

   task automatic test_random();
      rx_q.delete(); exp_q.delete();
      for (int c = 0; c < 400; c++) begin
         wr_en   = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         wr_data = 8'($urandom);
         step();
         checks++; if (int'(count) != m_q.size()) begin errors++; $display("FAIL rand_count c%0d: got %0d required %0d", c, count, m_q.size()); end
         checks++; if (overflow !== m_ovf)        begin errors++; $display("FAIL rand_ovf c%0d: got %b required %b", c, overflow, m_ovf); end
         checks++; if (busy !== !m_free)          begin errors++; $display("FAIL rand_busy c%0d: got %b required %b", c, busy, !m_free); end
         checks++; if (full !== (m_q.size() == DEPTH)) begin errors++; $display("FAIL rand_full c%0d: got %b required %b", c, full, m_q.size() == DEPTH); end
         checks++; if (empty !== (m_q.size() == 0))    begin errors++; $display("FAIL rand_empty c%0d: got %b required %b", c, empty, m_q.size() == 0); end
      end
      wr_en = 1'b0;
      drain();
      checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_frames: got %0d required %0d", rx_q.size(), exp_q.size()); end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_frame%0d: got %h required %h", i, rx_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      rst = 1'b1; step(); rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_data = 8'($urandom);
         step();
      end
      wr_en = 1'b0;
      while (tx !== 1'b0 && n < 200) begin step(); n++; end
      checks++; if (n >= 200) begin errors++; $display("FAIL rstmid_start_bit: waited %0d cycles, required < 200", n); end
      repeat (40) step();
      checks++; if (count !== 5'd3) begin errors++; $display("FAIL rstmid_queued: got %0d required 3", count); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL rstmid_count: got %0d required 0", count); end
      checks++; if (newd !== 1'b0)  begin errors++; $display("FAIL rstmid_newd: got %b required 0", newd); end
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rstmid_busy: got %b required 0", busy); end
      rx_q.delete(); exp_q.delete();
      repeat (600) step();
      checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL rstmid_frames: got %0d required 0", rx_q.size()); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rstmid_busy_late: got %b required 0", busy); end
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_full_push();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO and transmit sequencer upstream of the UART transmitter. A producer in the `clk` domain pushes bytes at any rate up to one per cycle. The block buffers them and hands them one at a time to the transmitter over its `newd`/`dintx`/`donetx` interface. It observes the serial `tx` line so that each byte is presented to the transmitter exactly once.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `AW`, `$clog2(DEPTH)`: pointer width; derived, not overridden.
- `clk` in 1: system clock; same clock that drives the transmitter.
- `rst` in 1: reset rst, synchronous, active-high; clock clk.
- `wr_en` in 1: push request.
- `wr_data` in 8: byte to push.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `count` out AW+1: bytes stored; excludes the byte currently handed to the transmitter.
- `overflow` out 1: sticky; set when a push is dropped; cleared only by `rst`.
- `busy` out 1: high in every state except IDLE.
- `newd` out 1: start request to the transmitter.
- `dintx` out 8: byte for the transmitter; stable while not IDLE.
- `tx` in 1: transmitter serial output, monitored.
- `donetx` in 1: transmitter completion flag; high for one uclk period, i.e. many `clk` cycles.

## Operation
- Storage: DEPTH×8 register array with write pointer `wp` and read pointer `rp`, both AW bits and wrapping modulo DEPTH, plus a separate `count` register.
- Push: accepted when `wr_en && (count < DEPTH || pop)`, where `pop` is the same-cycle read defined below.
  - An accepted push writes `mem[wp]` and increments `wp`.
  - When `wr_en && full && !pop`, the byte is dropped, `overflow` is set, and `wp` and `count` are unchanged.
- Count update: `count` += push − pop. A simultaneous push and pop leaves `count` unchanged.
- Edge detect: registers `tx_q` and `done_q` hold the previous-cycle values of `tx` and `donetx`.
  - `tx_fall = tx_q & ~tx`.
  - `done_rise = donetx & ~done_q`.
- FSM states:
  - IDLE: `newd`=0. If `!empty`, then `pop`=1: `dintx <= mem[rp]`, `rp++`, go to REQ.
  - REQ: `newd`=1. Hold until `tx_fall`, then `newd`=0 and go to WAIT_DONE.
  - WAIT_DONE: `newd`=0. On `done_rise`, go to GAP.
  - GAP: one cycle, then IDLE. This ensures `newd` is never re-asserted in the same cycle as `done_rise`.
- Dropping `newd` on `tx_fall` guarantees that the transmitter, which samples `newd` only on uclk edges in its idle state, starts exactly one frame per popped byte.
- A `done_rise` seen in REQ or IDLE is ignored; only WAIT_DONE consumes it.
- No timeout. If `tx` never falls, the FSM stays in REQ. This is the documented hang condition.
- Reset mid-operation:
  - FIFO contents are discarded: `wp`, `rp` and `count` go to 0.
  - FSM goes to IDLE and `newd` drops in the cycle after `rst`.
  - The byte in flight is lost. The transmitter is reset by the same `rst`.

## Timing
- Reset values: `full`=0, `empty`=1, `count`=0, `overflow`=0, `busy`=0, `newd`=0, `dintx`=8'h00, `tx_q`=1, `done_q`=0, state IDLE.
- Push latency: `count`, `empty` and `full` update on the clock edge after `wr_en`.
- Push to `newd`: a byte written into an empty FIFO while in IDLE gives IDLE→REQ on the next edge.
  - `newd` is high two edges after the `wr_en` edge.
  - `count` returns to 0 in that same cycle.
- `dintx` is registered at the IDLE→REQ transition and held through WAIT_DONE and GAP.
- `newd` falls on the edge following the first cycle in which `tx`=0.
- Back-to-back bytes: the next IDLE→REQ occurs 2 cycles after `done_rise`, i.e. after the GAP cycle.
- All outputs are registered. No combinational path from `tx` or `donetx` to `newd`.

## Test plan
- Reset then idle, with uart_tx (1 MHz, 9600 baud) attached:
  - `empty`=1, `count`=0, `newd`=0, `tx`=1 for 2000 cycles.
- Single push of 8'hA5:
  - `newd` rises 2 cycles later with `dintx`=8'hA5.
  - `newd` falls within one uclk period (≤106 clk) of `tx`=0.
  - The serial frame decodes LSB-first to A5.
  - `busy` deasserts after `donetx`.
- Burst push of 8'h01..8'h05 on consecutive cycles:
  - `count` peaks at 4 (the first byte is popped immediately).
  - The `tx` line carries exactly five frames in order 01,02,03,04,05, each frame exactly once.
- Overflow, DEPTH=16: push 18 bytes while the transmitter is busy with byte 0.
  - `full`=1 at `count`=16 and `overflow` sets.
  - Exactly 17 frames are transmitted; the last byte is dropped.
- Push while full in the IDLE pop cycle:
  - Simultaneous pop and push are both accepted.
  - `count` stays 16 and `overflow` stays 0.
- `rst` asserted mid-frame with 3 bytes queued:
  - Next cycle: `count`=0, `newd`=0, `busy`=0.
  - No further frames after reset.
